pipe_sequencer: RTL and testbench

PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

---
 rtl/pipe_sequencer.sv | 173 +++++++++++++++++
 tb/tb_pipe_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_sequencer.sv
// pipe_sequencer: program-counter and stage-occupancy sequencer for an
// in-order pipeline. Stage 0 is fetch and stage STAGES-1 is write-back.
//
// Control precedence, evaluated every cycle outside HALTED:
//   redirect > stall > normal advance.
// - A redirect loads redirect_pc. It squashes stages 0..BR_STAGE-1, which are
//   younger than the branch, so stages 0..BR_STAGE hold bubbles after the
//   edge. The branch itself moves on.
// - A stall freezes pc and stages 0..STALL_STAGE-1. Stage STALL_STAGE takes a
//   bubble and the older stages drain forward.
// - A halt word seen in stage 0 stops fetching. The machine then drains
//   until the marked instruction reaches write-back, and stays HALTED until
//   reset.
// Bubbles always carry a PC of 0 and a cleared halt mark.
module pipe_sequencer #(
  parameter int STAGES      = 4,
  parameter int PC_W        = 32,
  parameter int BR_STAGE    = 2,
  parameter int STALL_STAGE = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [PC_W-1:0]          redirect_pc,
  input  logic                     halt_in,
  output logic [PC_W-1:0]          pc,
  output logic [STAGES*PC_W-1:0]   pc_pipe,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES-1:0]        stage_load,
  output logic [STAGES-1:0]        stage_kill,
  output logic                     halt,
  output logic [1:0]               state_dbg
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t                       r_state;
  logic                         r_halt;
  logic [PC_W-1:0]              r_pc;
  logic [STAGES-1:0][PC_W-1:0]  r_pc_pipe;
  logic [STAGES-1:0]            r_valid;
  logic [STAGES-1:0]            r_hmark;

  logic                         w_halted;
  logic                         w_redirect;
  logic                         w_stall;
  logic                         w_halt_seen;
  logic                         w_fetch;
  logic                         w_fetch_v;
  logic [STAGES-1:0]            w_mark;

  // Redirect wins over stall; in HALTED every request is ignored.
  assign w_halted    = (r_state == ST_HALTED);
  assign w_redirect  = redirect & ~w_halted;
  assign w_stall     = stall & ~redirect & ~w_halted;
  assign w_halt_seen = (r_state == ST_RUN) & halt_in & r_valid[0];
  // Fetch only in RUN and not on the edge that spots the halt word. On that
  // edge the next address must not enter the pipe.
  assign w_fetch     = (r_state == ST_RUN) & ~w_halt_seen;
  assign w_fetch_v   = w_fetch & en;

  // Live halt mark per stage. Stage 0 takes it from halt_in, or from its own
  // latched copy when a stall held the halt word in place.
  always_comb begin
    w_mark    = '0;
    w_mark[0] = r_valid[0] & (halt_in | r_hmark[0]);
    for (int k = 1; k < STAGES; k++) begin
      w_mark[k] = r_valid[k] & r_hmark[k];
    end
  end

  // Sequencer FSM: RUN -> DRAIN on a halt word, DRAIN -> RUN on redirect,
  // DRAIN -> HALTED when the halt reaches write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_halt  <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (!redirect && halt_in && r_valid[0]) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (redirect) begin
            r_state <= ST_RUN;
          end else if (w_mark[STAGES-1]) begin
            r_state <= ST_HALTED;
            r_halt  <= 1'b1;
          end
        end
        ST_HALTED: begin
          r_state <= ST_HALTED;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  // Fetch address: jump on redirect, hold on stall/drain/halt, else step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
    end else if (!w_halted) begin
      if (w_redirect) begin
        r_pc <= redirect_pc;
      end else if (!w_stall && w_fetch) begin
        // en qualifies the fetched word; the address stream keeps advancing.
        r_pc <= r_pc + PC_W'(1);
      end
    end
  end

  // Stage registers: PC, valid and halt mark move together through the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_pipe <= '0;
      r_valid   <= '0;
      r_hmark   <= '0;
    end else if (!w_halted) begin
      if (w_redirect) begin
        r_valid[0]   <= 1'b0;
        r_hmark[0]   <= 1'b0;
        r_pc_pipe[0] <= '0;
      end else if (w_stall) begin
        r_hmark[0]   <= w_mark[0];
      end else begin
        r_valid[0]   <= w_fetch_v;
        r_pc_pipe[0] <= w_fetch_v ? r_pc : '0;
        r_hmark[0]   <= 1'b0;
      end
      for (int k = 1; k < STAGES; k++) begin
        if ((w_redirect && (k <= BR_STAGE)) || (w_stall && (k == STALL_STAGE))) begin
          r_valid[k]   <= 1'b0;
          r_hmark[k]   <= 1'b0;
          r_pc_pipe[k] <= '0;
        end else if (!(w_stall && (k < STALL_STAGE))) begin
          r_valid[k]   <= r_valid[k-1];
          r_hmark[k]   <= w_mark[k-1];
          r_pc_pipe[k] <= r_pc_pipe[k-1];
        end
      end
    end
  end

  // Per-stage load/kill strobes for the datapath; quiet in reset and HALTED.
  always_comb begin
    stage_load = '0;
    stage_kill = '0;
    if (rst_n && !w_halted) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_load[k] = !(w_stall && (k < STALL_STAGE));
        stage_kill[k] = w_redirect && (k < BR_STAGE);
      end
    end
  end

  assign pc          = r_pc;
  assign pc_pipe     = r_pc_pipe;
  assign stage_valid = r_valid;
  assign halt        = r_halt;
  assign state_dbg   = r_state;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Bench for pipe_sequencer. Two instances run side by side on the same
// inputs: A uses the defaults (4 stages, 32-bit PC, branch stage 2, stall
// stage 2) and B uses 6 stages, a 16-bit PC, branch stage 3 and stall
// stage 2. cfg selects which instance the monitor checks.
module tb_pipe_sequencer;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, stall, redirect, halt_in;
  logic [31:0] redirect_pc;

  logic [31:0]     a_pc;
  logic [4*32-1:0] a_pp;
  logic [3:0]      a_v, a_load, a_kill;
  logic            a_halt;
  logic [1:0]      a_st;

  logic [15:0]     b_pc;
  logic [6*16-1:0] b_pp;
  logic [5:0]      b_v, b_load, b_kill;
  logic            b_halt;
  logic [1:0]      b_st;

  pipe_sequencer #(.STAGES(4), .PC_W(32), .BR_STAGE(2), .STALL_STAGE(2)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt_in(halt_in), .pc(a_pc), .pc_pipe(a_pp),
    .stage_valid(a_v), .stage_load(a_load), .stage_kill(a_kill),
    .halt(a_halt), .state_dbg(a_st)
  );

  pipe_sequencer #(.STAGES(6), .PC_W(16), .BR_STAGE(3), .STALL_STAGE(2)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc[15:0]), .halt_in(halt_in), .pc(b_pc), .pc_pipe(b_pp),
    .stage_valid(b_v), .stage_load(b_load), .stage_kill(b_kill),
    .halt(b_halt), .state_dbg(b_st)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    int                 tag;
    logic               c_pc;   logic [31:0] pc;
    logic [7:0]         pp_m;   logic [7:0][31:0] pp;
    logic [7:0]         v_m;    logic [7:0] v;
    logic               c_halt; logic halt;
    logic               c_load; logic [7:0] load;
    logic               c_kill; logic [7:0] kill;
    logic               c_st;   logic [1:0] st;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  exp_t m_e;
  int   total = 0;
  int   bad   = 0;
  int   step_no = 0;
  int   cfg = 0;
  int   S, BR, SS;
  logic [31:0] pcm;
  logic [7:0]  all_m;

  logic [31:0] m_pc;
  logic [31:0] m_pp [8];
  logic [7:0]  m_v, m_load, m_kill;
  logic        m_halt;
  logic [1:0]  m_st;

  function automatic logic [7:0] low(input int n);
    return 8'((1 << n) - 1);
  endfunction

  task automatic clr_exp();
    e.c_pc = 1'b0; e.pc = '0; e.pp_m = '0; e.pp = '0; e.v_m = '0; e.v = '0;
    e.c_halt = 1'b0; e.halt = 1'b0; e.c_load = 1'b0; e.load = '0;
    e.c_kill = 1'b0; e.kill = '0; e.c_st = 1'b0; e.st = '0; e.tag = 0;
  endtask

  task automatic ex_pc(input logic [31:0] v);  e.c_pc = 1'b1; e.pc = v & pcm; endtask
  task automatic ex_pp(input int k, input logic [31:0] v); e.pp_m[k] = 1'b1; e.pp[k] = v; endtask
  task automatic ex_v(input logic [7:0] m, input logic [7:0] v); e.v_m = m; e.v = v; endtask
  task automatic ex_halt(input logic v); e.c_halt = 1'b1; e.halt = v; endtask
  task automatic ex_load(input logic [7:0] v); e.c_load = 1'b1; e.load = v; endtask
  task automatic ex_kill(input logic [7:0] v); e.c_kill = 1'b1; e.kill = v; endtask
  task automatic ex_st(input logic [1:0] v); e.c_st = 1'b1; e.st = v; endtask

  task automatic check(input string nm, input int idx, input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s[%0d] step=%0d cfg=%0d got=%h exp=%h", nm, idx, m_e.tag, cfg, got, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change just after a falling edge; the pushed record describes the
  // outputs seen at the following falling edge (after one rising edge).
  task automatic drive(input logic r, input logic en_i, input logic st_i,
                       input logic rd_i, input logic [31:0] rpc, input logic hi);
    @(negedge clk);
    #1;
    rst_n = r; en = en_i; stall = st_i; redirect = rd_i; redirect_pc = rpc; halt_in = hi;
    step_no++;
    e.tag = step_no;
    exp_q.push_back(e);
    clr_exp();
  endtask

  task automatic reset_only();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic run_fetch(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        m_e = exp_q.pop_front();
        for (int k = 0; k < 8; k++) m_pp[k] = '0;
        if (cfg == 0) begin
          m_pc = a_pc; m_v = {4'b0, a_v}; m_load = {4'b0, a_load};
          m_kill = {4'b0, a_kill}; m_halt = a_halt; m_st = a_st;
          for (int k = 0; k < 4; k++) m_pp[k] = a_pp[k*32 +: 32];
        end else begin
          m_pc = {16'b0, b_pc}; m_v = {2'b0, b_v}; m_load = {2'b0, b_load};
          m_kill = {2'b0, b_kill}; m_halt = b_halt; m_st = b_st;
          for (int k = 0; k < 6; k++) m_pp[k] = {16'b0, b_pp[k*16 +: 16]};
        end
        if (m_e.c_pc) check("pc", 0, m_pc, m_e.pc);
        for (int k = 0; k < 8; k++) begin
          if (m_e.pp_m[k]) check("pc_pipe", k, m_pp[k], m_e.pp[k]);
        end
        if (m_e.v_m != 8'h00) check("stage_valid", 0, {24'b0, m_v & m_e.v_m}, {24'b0, m_e.v & m_e.v_m});
        if (m_e.c_halt) check("halt", 0, {31'b0, m_halt}, {31'b0, m_e.halt});
        if (m_e.c_load) check("stage_load", 0, {24'b0, m_load}, {24'b0, m_e.load});
        if (m_e.c_kill) check("stage_kill", 0, {24'b0, m_kill}, {24'b0, m_e.kill});
        if (m_e.c_st)   check("state", 0, {30'b0, m_st}, {30'b0, m_e.st});
      end
    end
  end

  // ---------------- directed suite ----------------
  task automatic run_suite();
    // Reset: everything clear, strobes quiet even with redirect/stall high.
    ex_pc(0); for (int k = 0; k < S; k++) ex_pp(k, 0);
    ex_v(all_m, 8'h00); ex_halt(1'b0); ex_load(8'h00); ex_kill(8'h00); ex_st(ST_RUN);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'hffff_ffff, 1'b1);

    // Straight-line run: first edge fetches pc 0, six edges reach pc 6.
    ex_pc(1); ex_pp(0, 0); ex_v(all_m, 8'h01);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    run_fetch(4);
    ex_pc(6); for (int k = 0; k < S; k++) ex_pp(k, 32'(5 - k));
    ex_v(all_m, all_m); ex_load(all_m); ex_kill(8'h00); ex_st(ST_RUN);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    // en=0 puts a bubble with PC 0 into stage 0.
    ex_pp(0, 0); ex_pp(1, 5); ex_v(8'h03, 8'h02);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Stall for two edges at pc 4.
    reset_only(); run_fetch(4);
    ex_pc(4); ex_pp(0, 3); ex_pp(1, 2); ex_pp(2, 0); ex_pp(3, 1); ex_v(8'h0f, 8'h0b);
    ex_load(all_m & ~low(SS)); ex_kill(8'h00);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    ex_pc(4); ex_pp(0, 3); ex_pp(1, 2); ex_pp(2, 0); ex_pp(3, 0); ex_v(8'h0f, 8'h03);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    ex_pc(5); ex_pp(0, 4); ex_pp(1, 3); ex_pp(2, 2); ex_pp(3, 0); ex_v(8'h0f, 8'h07);
    ex_load(all_m);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // Branch with stage BR at pc 7; second pass adds stall and halt_in.
    for (int s = 0; s < 2; s++) begin
      reset_only(); run_fetch(8 + BR);
      ex_pc(32'h40); for (int k = 0; k <= BR; k++) ex_pp(k, 0); ex_pp(BR + 1, 7);
      ex_v(low(BR + 2), 8'(1 << (BR + 1))); ex_kill(low(BR)); ex_load(all_m); ex_st(ST_RUN);
      drive(1'b1, 1'b1, 1'(s), 1'b1, 32'h40, 1'(s));
      ex_pc(32'h41); ex_pp(0, 32'h40); ex_v(8'h01, 8'h01); ex_kill(8'h00);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    end

    // Halt word in stage 0 at pc 9: drain, halt after STAGES-1 edges.
    reset_only(); run_fetch(10);
    ex_st(ST_DRAIN); ex_pc(10); ex_pp(0, 0); ex_pp(1, 9); ex_v(8'h03, 8'h02); ex_halt(1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 1; i <= S - 2; i++) begin
      ex_st(ST_DRAIN); ex_pc(10); ex_halt(1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    end
    ex_st(ST_HALTED); ex_pc(10); ex_halt(1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    ex_st(ST_HALTED); ex_pc(10); ex_halt(1'b1); ex_load(8'h00); ex_kill(8'h00);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 1'b0);
    ex_st(ST_HALTED); ex_pc(10); ex_halt(1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1);
    // Reset out of HALTED, then the first edge fetches pc 0 again.
    ex_pc(0); ex_halt(1'b0); ex_st(ST_RUN); ex_v(all_m, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    ex_pc(1); ex_pp(0, 0); ex_v(8'h01, 8'h01);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // Speculative halt killed by a redirect one edge later.
    reset_only(); run_fetch(10);
    ex_st(ST_DRAIN);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    ex_st(ST_RUN); ex_pc(32'h20); ex_halt(1'b0); ex_v(low(BR + 1), 8'h00); ex_kill(low(BR));
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0);
    run_fetch(S + 1);
    ex_pc(32'(32'h20 + S + 2)); ex_pp(0, 32'(32'h20 + S + 1)); ex_halt(1'b0);
    ex_st(ST_RUN); ex_v(all_m, all_m);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // PC wrap: all-ones increments to zero.
    reset_only(); run_fetch(1);
    ex_pc(32'hffff_ffff);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hffff_ffff, 1'b0);
    ex_pc(0); ex_pp(0, pcm); ex_v(8'h01, 8'h01);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    repeat (3) @(negedge clk);
  endtask

  // ---------------- main / final report ----------------
  initial begin
    rst_n = 1'b0; en = 1'b0; stall = 1'b0; redirect = 1'b0; halt_in = 1'b0;
    redirect_pc = '0;
    clr_exp();
    for (int c = 0; c < 2; c++) begin
      cfg = c;
      if (c == 0) begin
        S = 4; BR = 2; SS = 2; pcm = 32'hffff_ffff;
      end else begin
        S = 6; BR = 3; SS = 2; pcm = 32'h0000_ffff;
      end
      all_m = low(S);
      run_suite();
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
